irq_priority_ctrl: RTL and testbench
====================================

Name: irq_priority_ctrl

Overview:
- 8-source interrupt request controller that sits directly upstream of the 8-to-3 priority encoder stage.
- Edge-detects request lines into a pending register, masks them, and uses fixed priority (bit 7 highest) to pick one source.
- Presents the winner to a CPU-side consumer with a req/ack handshake, then holds the service state until end-of-interrupt.
- Turns the encoder's combinational i/o/v function into a stateful, handshaked interrupt path.

Parameters:
- N, 8, number of request sources; must equal 2**IDW.
- IDW, 3, width of the source index output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- irq  input  N  raw request lines, one per source.
- mask  input  N  1 = source excluded from selection; its pending bit is still recorded.
- en  input  1  global enable for issuing new requests.
- ack  input  1  single-cycle consumer acknowledge of the current req.
- eoi  input  1  single-cycle end-of-interrupt from the consumer.
- req  output  1  request valid; id is meaningful while high.
- id  output  IDW  index of the selected source.
- in_svc  output  1  high while a source is being serviced.
- pend  output  N  pending register, for status readout.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, pend=0, irq_d=0, req=0, id=0, in_svc=0.
  - irq_d resets to 0, so a line already high when reset is released produces exactly one pending edge.
- Edge detect: irq_d <= irq every cycle. pend[k] is set when irq[k]=1 and irq_d[k]=0 at a clock edge. mask does not affect this setting.
- Candidate vector: c = pend & ~mask. The winner is the highest set index of c, so bit 7 beats bit 0.
- IDLE state:
  - if en=1 and c!=0: at the next edge go to REQ, latch id = winner, set req=1.
  - otherwise stay in IDLE with req=0.
- REQ state:
  - id is frozen for the whole state; mask or pend changes do not re-arbitrate (no preemption).
  - ack=1: clear pend[id], go to SERV, req=0, in_svc=1, all on the same edge.
  - if ack=1 and a new rising edge on irq[id] occur in the same cycle, set wins and pend[id] stays 1.
  - en=0 with ack=0: go to IDLE, req=0, pend unchanged (request retracted).
  - ack and en=0 in the same cycle: ack wins.
- SERV state:
  - in_svc=1 and req=0; en is ignored.
  - eoi=1: go to IDLE, in_svc=0. id holds its last value.
  - new edges keep accumulating in pend.
- Ignored inputs: ack outside REQ; eoi outside SERV; eoi in REQ, including when it arrives in the same cycle as ack.
- Latency:
  - irq sampled high at edge E (irq_d low) sets pend after E.
  - req is high after E+1, i.e. 2 cycles, when IDLE, en=1 and the source is unmasked.
  - After eoi at edge F, the next req appears after F+1 if c!=0.
- Reset mid-operation: any state returns to IDLE and all pending requests are discarded.
- Only the rising edge of irq matters: a line held high yields a single request, and a pulse one cycle wide is captured.

Optional Feature:
- Macro: IRQ_CTRL_LEVEL_EN.
- Defined (level-sensitive mode):
  - pend <= irq every cycle; there is no edge detect and no sticky bits.
  - ack does not clear pend.
  - The source must drop its line before eoi, otherwise it re-requests.
- Undefined: edge-triggered sticky pend, exactly as described above.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles with irq=0 -> req=0, id=0, in_svc=0, pend=8'h00. Release rst with irq=8'h00 for 5 cycles -> outputs unchanged.
2. Single source: en=1, mask=0, irq=8'b1000_0000 pulsed for 1 cycle -> pend=8'h80, req=1 two edges later with id=7. ack -> req=0, in_svc=1, pend=8'h00. eoi -> in_svc=0.
3. Priority and masking: irq=8'b0100_0100 rises with mask=8'b0100_0000 -> id=2. Service it; then drop the mask -> id=6 issued next, with pend=8'h40 before its ack.
4. Accumulation: irq=8'b0011_0111 rises together -> requests served in order 5,4,2,1,0, one per ack/eoi pair. pend ends at 8'h00.
5. Enable gating: en=0 with irq=8'h80 rising -> pend=8'h80, req=0. Raise en -> req=1, id=7 after one edge. Drop en before ack -> req=0, pend=8'h80 kept.
6. Reset mid-service: in SERV with pend=8'h24, assert rst -> state IDLE, pend=0, in_svc=0. Stray ack/eoi pulses in IDLE -> no effect.

Source files
------------

// File: rtl/irq_priority_ctrl_if.sv
// irq_priority_ctrl_if: request/mask/handshake bundle between interrupt sources, consumer and irq_priority_ctrl
interface irq_priority_ctrl_if #(parameter int N = 8, parameter int IDW = 3);
  logic [N-1:0] irq;
  logic [N-1:0] mask;
  logic en;
  logic ack;
  logic eoi;
  logic req;
  logic [IDW-1:0] id;
  logic in_svc;
  logic [N-1:0] pend;
  modport master (output irq, mask, en, ack, eoi, input req, id, in_svc, pend);
  modport slave (input irq, mask, en, ack, eoi, output req, id, in_svc, pend);
endinterface

// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: fixed-priority (bit N-1 highest) interrupt controller with req/ack/eoi handshake; IRQ_CTRL_LEVEL_EN selects level-sensitive pend
module irq_priority_ctrl #(
  parameter int N = 8,
  parameter int IDW = 3
) (
  input logic clk,
  input logic rst,
  irq_priority_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;
  state_t state, state_n;
  logic [N-1:0] pend, pend_n, c;
  logic [IDW-1:0] id, id_n, win;
  assign c = pend & ~bus.mask;
  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) win = c[i] ? IDW'(i) : win;
  end
`ifdef IRQ_CTRL_LEVEL_EN
  assign pend_n = bus.irq;
`else
  logic [N-1:0] irq_d, clr;
  // a new edge on the acked source in the same cycle survives the clear
  assign clr = (state == REQ && bus.ack) ? N'(1) << id : '0;
  assign pend_n = (pend & ~clr) | (bus.irq & ~irq_d);
  always_ff @(posedge clk) irq_d <= rst ? '0 : bus.irq;
`endif
  always_comb begin
    state_n = state;
    id_n = id;
    case (state)
      IDLE: begin
        state_n = (bus.en && |c) ? REQ : IDLE;
        id_n = (bus.en && |c) ? win : id;
      end
      REQ: state_n = bus.ack ? SERV : (!bus.en ? IDLE : REQ);
      SERV: state_n = bus.eoi ? IDLE : SERV;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      id <= '0;
      pend <= '0;
    end else begin
      state <= state_n;
      id <= id_n;
      pend <= pend_n;
    end
  end
  assign bus.req = state == REQ;
  assign bus.in_svc = state == SERV;
  assign bus.id = id;
  assign bus.pend = pend;
endmodule

// File: tb/tb_irq_priority_ctrl.sv
// tb_irq_priority_ctrl: directed scoreboard bench; expected ids are queued by stimulus and popped by a monitor on each new req
module tb_irq_priority_ctrl;
  logic clk = 0;
  logic rst;
  int n_cmp = 0;
  int n_fail = 0;
  int exp_q[$];
  logic req_q = 0;
  irq_priority_ctrl_if #(.N(8), .IDW(3)) bus ();
  irq_priority_ctrl #(.N(8), .IDW(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (!bus.req && k < 12) begin
      step();
      k++;
    end
    chk({name, "_req_timeout"}, int'(bus.req), 1);
  endtask

  task automatic serve(input int exp_id);
    exp_q.push_back(exp_id);
    wait_req("serve");
    chk("serve_id", int'(bus.id), exp_id);
    bus.ack = 1;
    step();
    bus.ack = 0;
    chk("serve_in_svc", int'(bus.in_svc), 1);
    bus.eoi = 1;
    step();
    bus.eoi = 0;
    chk("serve_eoi", int'(bus.in_svc), 0);
  endtask

  // monitor: every fresh req must match the oldest queued expectation
  always @(negedge clk) begin
    if (bus.req && !req_q) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL mon_unexpected_req: got id %0d expected no req", bus.id);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(bus.id) != e) begin
          n_fail++;
          $display("FAIL mon_id: got %0d expected %0d", bus.id, e);
        end
      end
    end
    req_q <= bus.req;
  end

  initial begin
    rst = 1;
    bus.irq = 0; bus.mask = 0; bus.en = 0; bus.ack = 0; bus.eoi = 0;
    step(2);
    chk("rst_req", int'(bus.req), 0);
    chk("rst_id", int'(bus.id), 0);
    chk("rst_in_svc", int'(bus.in_svc), 0);
    chk("rst_pend", int'(bus.pend), 0);
    rst = 0;
    step(5);
    chk("idle_req", int'(bus.req), 0);
    chk("idle_pend", int'(bus.pend), 0);
    chk("idle_in_svc", int'(bus.in_svc), 0);
    // single source, one-cycle pulse
    bus.en = 1;
    bus.irq = 8'h80;
    exp_q.push_back(7);
    step();
    chk("single_pend", int'(bus.pend), 'h80);
    chk("single_req_early", int'(bus.req), 0);
    bus.irq = 0;
    step();
    chk("single_req", int'(bus.req), 1);
    chk("single_id", int'(bus.id), 7);
    bus.ack = 1;
    step();
    bus.ack = 0;
    chk("single_ack_req", int'(bus.req), 0);
    chk("single_ack_svc", int'(bus.in_svc), 1);
    chk("single_ack_pend", int'(bus.pend), 0);
    bus.eoi = 1;
    step();
    bus.eoi = 0;
    chk("single_eoi", int'(bus.in_svc), 0);
    // masking hides the higher source
    bus.mask = 8'h40;
    bus.irq = 8'h44;
    exp_q.push_back(2);
    step();
    bus.irq = 0;
    step();
    chk("mask_id", int'(bus.id), 2);
    bus.ack = 1;
    step();
    bus.ack = 0;
    chk("mask_pend", int'(bus.pend), 'h40);
    bus.eoi = 1;
    step();
    bus.eoi = 0;
    step();
    chk("mask_hold_req", int'(bus.req), 0);
    bus.mask = 0;
    exp_q.push_back(6);
    step();
    chk("unmask_req", int'(bus.req), 1);
    chk("unmask_id", int'(bus.id), 6);
    chk("unmask_pend", int'(bus.pend), 'h40);
    bus.ack = 1;
    step();
    bus.ack = 0;
    chk("unmask_ack_pend", int'(bus.pend), 0);
    bus.eoi = 1;
    step();
    bus.eoi = 0;
    // accumulation with lines held high: each source requests once
    bus.irq = 8'h37;
    step();
    chk("acc_pend", int'(bus.pend), 'h37);
    serve(5);
    serve(4);
    serve(2);
    serve(1);
    serve(0);
    step(2);
    chk("acc_pend_end", int'(bus.pend), 0);
    chk("acc_req_end", int'(bus.req), 0);
    bus.irq = 0;
    step();
    // enable gating and retraction
    bus.en = 0;
    bus.irq = 8'h80;
    step();
    bus.irq = 0;
    step();
    chk("en_pend", int'(bus.pend), 'h80);
    chk("en_req_off", int'(bus.req), 0);
    bus.en = 1;
    exp_q.push_back(7);
    step();
    chk("en_req_on", int'(bus.req), 1);
    chk("en_id", int'(bus.id), 7);
    bus.en = 0;
    step();
    chk("retract_req", int'(bus.req), 0);
    chk("retract_pend", int'(bus.pend), 'h80);
    // ack with a simultaneous new edge on the same line keeps it pending; eoi in REQ ignored
    bus.en = 1;
    exp_q.push_back(7);
    step();
    chk("reissue_req", int'(bus.req), 1);
    bus.ack = 1;
    bus.eoi = 1;
    bus.irq = 8'h80;
    step();
    bus.ack = 0;
    bus.eoi = 0;
    bus.irq = 0;
    chk("setwins_pend", int'(bus.pend), 'h80);
    chk("setwins_svc", int'(bus.in_svc), 1);
    bus.eoi = 1;
    step();
    bus.eoi = 0;
    exp_q.push_back(7);
    step();
    chk("again_req", int'(bus.req), 1);
    bus.ack = 1;
    step();
    bus.ack = 0;
    // reset during service discards pending edges
    bus.irq = 8'h24;
    step();
    bus.irq = 0;
    step();
    chk("serv_pend", int'(bus.pend), 'h24);
    chk("serv_svc", int'(bus.in_svc), 1);
    chk("serv_req", int'(bus.req), 0);
    rst = 1;
    step();
    rst = 0;
    chk("midrst_pend", int'(bus.pend), 0);
    chk("midrst_svc", int'(bus.in_svc), 0);
    chk("midrst_req", int'(bus.req), 0);
    bus.ack = 1;
    bus.eoi = 1;
    step();
    bus.ack = 0;
    bus.eoi = 0;
    step(2);
    chk("stray_req", int'(bus.req), 0);
    chk("stray_svc", int'(bus.in_svc), 0);
    chk("stray_pend", int'(bus.pend), 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
